// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Port ids double as the round-robin "last granted" marker.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int LOCK_CNT_W = 8;

   typedef enum logic {
      FREE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef enum logic {
      IF   = 1'b0,
      DATA = 1'b1
   } port_id_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick between fetch and data requesters.
// gnt[0] = fetch, gnt[1] = data; at most one bit set.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic       req_if,
   input  logic       req_d,
   input  port_id_t   last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req_if && req_d) begin
         // Contention goes to whichever port was not served most recently.
         if (last == DATA) gnt = 2'b01;
         else              gnt = 2'b10;
      end else if (req_if) begin
         gnt = 2'b01;
      end else if (req_d) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port unified memory between fetch and load/store,
// with round-robin fairness and a bounded lock for LM/SM bursts.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_LOCK = 8
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_lock,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_rwbar,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [LOCK_CNT_W-1:0] MAX_CNT = LOCK_CNT_W'(MAX_LOCK);

   arb_state_t            state_q, state_d;
   port_id_t              last_q, last_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic                  pend_if, pend_d;
   logic [1:0]            rr_gnt;
   logic                  if_gnt_c, d_gnt_c;

   mem_arb_rr2 u_rr (
      .req_if (if_req),
      .req_d  (d_req),
      .last   (last_q),
      .gnt    (rr_gnt)
   );

   // Lock FSM: next state, counter and grant decision.
   always_comb begin
      if_gnt_c   = 1'b0;
      d_gnt_c    = 1'b0;
      state_d    = state_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;

      if (state_q == FREE || !d_lock) begin
         // Dropping d_lock releases the memory in the same cycle.
         if_gnt_c   = rr_gnt[0];
         d_gnt_c    = rr_gnt[1];
         state_d    = FREE;
         lock_cnt_d = '0;
         if (rr_gnt[1] && d_lock) begin
            state_d    = LOCKED;
            lock_cnt_d = LOCK_CNT_W'(1);
         end
      end else if (lock_cnt_q == MAX_CNT && if_req) begin
         // Budget exhausted: fetch gets one slot, lock is kept.
         if_gnt_c   = 1'b1;
         lock_cnt_d = '0;
      end else if (d_req) begin
         d_gnt_c = 1'b1;
         if (lock_cnt_q != MAX_CNT) lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
      end

      if (if_gnt_c)     last_d = IF;
      else if (d_gnt_c) last_d = DATA;
   end

   // No grant may escape while reset is asserted.
   assign if_gnt = if_gnt_c & resetn;
   assign d_gnt  = d_gnt_c & resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= FREE;
         last_q     <= DATA;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Memory-side mux; idle drives a harmless read of address 0.
   always_comb begin
      mem_rwbar = 1'b1;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_rwbar = ~d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Return stage: steer registered read data to the issuing port.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_if <= 1'b0;
         pend_d  <= 1'b0;
      end else begin
         pend_if <= if_gnt;
         pend_d  <= d_gnt & ~d_we;
      end
   end

   assign if_rvalid = pend_if;
   assign d_rvalid  = pend_d;
   assign if_rdata  = pend_if ? mem_rdata : '0;
   assign d_rdata   = pend_d  ? mem_rdata : '0;

endmodule
